countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Upstream producer for the 7-segment display stage.
- Generates the `countdown_val` / `countdown_active` pair the display shows on DN1_K3/K4.
- Emits a one-cycle `timeout` pulse to the main FSM when a countdown expires.
- Loads a configurable number of seconds (from switches) on `start`, decrements once per second from a clock prescaler, and supports pause and cancel.

Parameters:
- TICK_DIV, 100000000, clk cycles per countdown step (1 s at 100 MHz); must be >= 2.
- DEFAULT_SEC, 10, load value used when `cfg_sec` == 0.
- MAX_SEC, 31, upper clamp for the load value (<= 31).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, (re)start countdown
- cancel  in  1  one-cycle pulse, abort countdown without timeout
- pause  in  1  level, freezes countdown while high
- cfg_sec  in  5  requested seconds, sampled on accepted start
- countdown_val  out  5  remaining seconds (0..31)
- countdown_active  out  1  high while RUN or PAUSED
- timeout  out  1  one-cycle pulse on natural expiry
- tick_cnt  out  27  prescaler value, debug/verification visibility (width = clog2(TICK_DIV))

Behaviour:
- Reset: clk and rst_n are the only clock/reset; reset is asynchronous, active-low.
  - state=IDLE, countdown_val=0, countdown_active=0, timeout=0, tick_cnt=0.
  - Reset mid-count returns to these values immediately, with no timeout.
- All outputs are registered.
- Load value L:
  - `cfg_sec` == 0 → DEFAULT_SEC.
  - `cfg_sec` > MAX_SEC → MAX_SEC.
  - Otherwise `cfg_sec`.
- States: IDLE, RUN, PAUSED. `countdown_active`=1 exactly in RUN and PAUSED.
- IDLE:
  - On start (and no cancel): countdown_val<=L, tick_cnt<=0.
  - Go to PAUSED if pause=1, else RUN.
- RUN:
  - tick_cnt increments each cycle and wraps TICK_DIV-1 → 0.
  - A tick occurs on the cycle tick_cnt==TICK_DIV-1.
  - On tick with countdown_val > 1: countdown_val decrements.
  - On tick with countdown_val == 1: countdown_val<=0, countdown_active<=0, timeout<=1 for exactly one cycle, state→IDLE, tick_cnt<=0.
  - pause=1 → PAUSED; tick_cnt holds and no tick is taken that cycle.
- PAUSED:
  - tick_cnt and countdown_val hold.
  - pause=0 → RUN; counting resumes from the held tick_cnt.
- Restart: start in RUN or PAUSED reloads L and clears tick_cnt.
  - Next state follows pause as from IDLE.
  - No timeout is generated, even if the same cycle would have been the final tick.
- Cancel in any state:
  - state→IDLE, countdown_val<=0, countdown_active<=0, tick_cnt<=0, no timeout.
  - Cancel wins over a simultaneous start or a final tick.
- Latency:
  - countdown_val=L and countdown_active=1 appear in the cycle after start.
  - First decrement occurs TICK_DIV cycles after that (no pause).
  - Total from start to timeout pulse = L×TICK_DIV+1 cycles.
- `timeout` never asserts outside the RUN→IDLE expiry transition.
- Timing: no divide or modulo in this block; the display stage performs the BCD split.

Test Plan:
1. TICK_DIV=4, cfg_sec=3, start pulse, pause=0 → countdown_val follows the sequence below; timeout high for one cycle exactly 13 cycles after start; active drops in the same cycle as the timeout.
   - 3 for 4 cycles, then 2 for 4, then 1 for 4, then 0.
2. cfg_sec=0 then cfg_sec=31 with MAX_SEC=20 → loads 10 and 20 respectively.
3. cfg_sec=5, pause=1 for 10 cycles after the first decrement → countdown_val holds at 4 and tick_cnt is frozen; after release, the remaining time is unchanged; timeout is delayed by exactly 10 cycles.
4. cfg_sec=2, cancel on the final tick cycle → no timeout; val=0, active=0. Cancel and start in the same cycle from IDLE → stays IDLE.
5. Restart at countdown_val=1 with cfg_sec=4 → val=4, tick_cnt=0, no timeout pulse, new full 4×TICK_DIV countdown.
6. rst_n low mid-RUN (asynchronous, between clock edges) → outputs clear immediately; after release the block stays IDLE until a start pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// Seconds countdown for the 7-segment stage: loads on start, steps once per TICK_DIV cycles,
// supports pause/cancel, and pulses timeout for one cycle on natural expiry.
module countdown_timer #(
  parameter  int TICK_DIV    = 100000000,
  parameter  int DEFAULT_SEC = 10,
  parameter  int MAX_SEC     = 31,
  localparam int TW          = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          cancel,
  input  logic          pause,
  input  logic [4:0]    cfg_sec,
  output logic [4:0]    countdown_val,
  output logic          countdown_active,
  output logic          timeout,
  output logic [TW-1:0] tick_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [4:0]    DEF_V    = 5'(DEFAULT_SEC);
  localparam logic [4:0]    MAX_V    = 5'(MAX_SEC);
  localparam logic [TW-1:0] TICK_TOP = TW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [4:0]    val_q, val_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          active_q, active_d;
  logic          timeout_q, timeout_d;
  logic [4:0]    load_val;

  always_comb begin
    if (cfg_sec == 5'd0)     load_val = DEF_V;
    else if (cfg_sec > MAX_V) load_val = MAX_V;
    else                      load_val = cfg_sec;
  end

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    tick_d    = tick_q;
    timeout_d = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      val_d   = 5'd0;
      tick_d  = '0;
    end else if (start) begin
      // A restart discards any tick due this cycle, so no timeout can escape.
      state_d = pause ? PAUSED : RUN;
      val_d   = load_val;
      tick_d  = '0;
    end else if (state_q != IDLE) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        // A PAUSED cycle with pause released already counts, so a pause of N
        // cycles delays expiry by exactly N cycles.
        state_d = RUN;
        if (tick_q == TICK_TOP) begin
          tick_d = '0;
          if (val_q > 5'd1) begin
            val_d = val_q - 5'd1;
          end else begin
            val_d     = 5'd0;
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      val_q     <= 5'd0;
      tick_q    <= '0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
    end
  end

  assign countdown_val    = val_q;
  assign countdown_active = active_q;
  assign timeout          = timeout_q;
  assign tick_cnt         = tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a
// remaining-cycles reference model.
module tb_countdown_timer;
  localparam int TD  = 4;
  localparam int DEF = 10;
  localparam int MAX = 20;
  localparam int TW  = $clog2(TD);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, cancel = 1'b0, pause = 1'b0;
  logic [4:0]    cfg_sec = 5'd0;
  logic [4:0]    countdown_val;
  logic          countdown_active, timeout;
  logic [TW-1:0] tick_cnt;

  countdown_timer #(.TICK_DIV(TD), .DEFAULT_SEC(DEF), .MAX_SEC(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .pause(pause),
    .cfg_sec(cfg_sec), .countdown_val(countdown_val),
    .countdown_active(countdown_active), .timeout(timeout), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  // Reference: remaining counting cycles until expiry.
  bit m_act = 0;
  int m_r   = 0;
  bit m_to  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic int load_of(input int c);
    if (c == 0) return DEF;
    if (c > MAX) return MAX;
    return c;
  endfunction

  function automatic int m_val();
    return m_act ? (m_r + TD - 1) / TD : 0;
  endfunction

  function automatic int m_tick();
    return m_act ? (TD - (m_r % TD)) % TD : 0;
  endfunction

  task automatic model_step();
    m_to = 0;
    if (cancel) begin
      m_act = 0; m_r = 0;
    end else if (start) begin
      m_act = 1; m_r = load_of(int'(cfg_sec)) * TD;
    end else if (m_act && !pause) begin
      m_r--;
      if (m_r == 0) begin
        m_act = 0; m_to = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("val",     int'(countdown_val),    m_val());
    check("active",  int'(countdown_active), int'(m_act));
    check("timeout", int'(timeout),          int'(m_to));
    check("tick",    int'(tick_cnt),         m_tick());
  endtask

  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; cancel = 0;
  endtask

  task automatic do_start(input int c, input bit p);
    cfg_sec = 5'(c); start = 1; pause = p;
    cyc();
    idle_inputs();
  endtask

  // Runs until timeout is seen; returns cycle count since t0.
  task automatic run_to_timeout(input int t0, input int budget, output int dt);
    int k;
    dt = -1;
    for (k = 0; k < budget; k++) begin
      cyc();
      if (timeout) begin
        dt = cyc_n - t0;
        break;
      end
    end
    if (dt < 0) check("timeout_bound", 0, 1);
  endtask

  initial begin
    int t0, dt;

    #12;
    check("rst_val",    int'(countdown_val), 0);
    check("rst_active", int'(countdown_active), 0);
    check("rst_tick",   int'(tick_cnt), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1;
    repeat (3) cyc();

    // 1: basic 3-second countdown
    t0 = cyc_n;
    do_start(3, 0);
    for (int i = 0; i < 12; i++) begin
      check("seq_val", int'(countdown_val), 3 - i / TD);
      if (i < 11) cyc();
    end
    run_to_timeout(t0, 20, dt);
    check("t1_latency", dt, 3 * TD + 1);
    check("t1_active_drop", int'(countdown_active), 0);
    cyc();
    check("t1_pulse_width", int'(timeout), 0);

    // 2: default and clamp
    do_start(0, 0);
    check("load_default", int'(countdown_val), DEF);
    cancel = 1; cyc(); idle_inputs();
    do_start(31, 0);
    check("load_clamp31", int'(countdown_val), MAX);
    do_start(21, 0);
    check("load_clamp21", int'(countdown_val), MAX);
    do_start(7, 0);
    check("load_plain", int'(countdown_val), 7);
    cancel = 1; cyc(); idle_inputs();

    // 3: pause after first decrement
    t0 = cyc_n;
    do_start(5, 0);
    repeat (TD) cyc();
    check("t3_first_dec", int'(countdown_val), 4);
    pause = 1;
    repeat (10) begin
      cyc();
      check("t3_hold_val", int'(countdown_val), 4);
      check("t3_hold_tick", int'(tick_cnt), 0);
    end
    pause = 0;
    run_to_timeout(t0, 60, dt);
    check("t3_latency", dt, 5 * TD + 1 + 10);
    cyc();

    // 4: cancel on the final tick, then cancel+start from IDLE
    do_start(2, 0);
    repeat (2 * TD - 1) cyc();
    check("t4_pre_val", int'(countdown_val), 1);
    cancel = 1;
    cyc();
    idle_inputs();
    check("t4_no_timeout", int'(timeout), 0);
    check("t4_val", int'(countdown_val), 0);
    check("t4_active", int'(countdown_active), 0);
    cancel = 1; start = 1; cfg_sec = 5'd6;
    cyc();
    idle_inputs();
    check("t4_cs_active", int'(countdown_active), 0);
    repeat (2) cyc();

    // 5: restart on the final tick
    do_start(1, 0);
    repeat (TD - 1) cyc();
    check("t5_pre_tick", int'(tick_cnt), TD - 1);
    t0 = cyc_n;
    do_start(4, 0);
    check("t5_val", int'(countdown_val), 4);
    check("t5_tick", int'(tick_cnt), 0);
    check("t5_no_timeout", int'(timeout), 0);
    run_to_timeout(t0, 40, dt);
    check("t5_latency", dt, 4 * TD + 1);

    // 6: asynchronous reset between edges
    do_start(6, 0);
    repeat (5) cyc();
    @(posedge clk); cyc_n++; model_step();
    #2 rst_n = 0;
    #1;
    m_act = 0; m_r = 0; m_to = 0;
    check("t6_val", int'(countdown_val), 0);
    check("t6_active", int'(countdown_active), 0);
    check("t6_tick", int'(tick_cnt), 0);
    check("t6_timeout", int'(timeout), 0);
    @(negedge clk) rst_n = 1;
    repeat (8) cyc();
    check("t6_stays_idle", int'(countdown_active), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 19) == 0);
      cancel  = ($urandom_range(0, 59) == 0);
      cfg_sec = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if (start && $urandom_range(0, 1) == 0) cfg_sec = 5'($urandom_range(0, 3));
      cyc();
    end
    idle_inputs();
    pause = 0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
